// File: rtl/oclib_reset_request_if.sv
// Signal bundle between a reset-cause source (master) and the reset-request
// initiator (slave).
interface oclib_reset_request_if;
   logic       swRequest;
   logic       buttonIn;
   logic       watchdogEnable;
   logic       watchdogKick;
   logic       resetDone;
   logic       causeClear;
   logic       resetRequest;
   logic       busy;
   logic [3:0] cause;
   logic [7:0] requestCount;

   modport master (
      output swRequest, buttonIn, watchdogEnable, watchdogKick, resetDone, causeClear,
      input  resetRequest, busy, cause, requestCount
   );

   modport slave (
      input  swRequest, buttonIn, watchdogEnable, watchdogKick, resetDone, causeClear,
      output resetRequest, busy, cause, requestCount
   );
endinterface

// File: rtl/oclib_reset_request.sv
// Reset-request initiator: merges reset causes into one clean, fixed-width request
// and waits for reset-done. Watchdog cause is built only with OCLIB_RESET_REQUEST_WATCHDOG_EN.
module oclib_reset_request #(
   parameter int RequestCycles     = 16,
   parameter int HoldoffCycles     = 64,
   parameter int DoneTimeoutCycles = 4096,
   parameter int DebounceCycles    = 1024,
   parameter int WatchdogCycles    = 1048576,
   parameter int SyncCycles        = 3,
   parameter int ButtonActiveLow   = 1,
   parameter int RequestActiveLow  = 0
) (
   input logic                    clock,
   input logic                    reset,
   oclib_reset_request_if.slave   rr
);

   localparam int ReqW  = (RequestCycles     > 1) ? $clog2(RequestCycles)     : 1;
   localparam int HoldW = (HoldoffCycles     > 1) ? $clog2(HoldoffCycles)     : 1;
   localparam int DoneW = (DoneTimeoutCycles > 1) ? $clog2(DoneTimeoutCycles) : 1;
   localparam int DebW  = (DebounceCycles    > 1) ? $clog2(DebounceCycles)    : 1;

   localparam logic [ReqW-1:0]  ReqLast   = ReqW'(RequestCycles - 1);
   localparam logic [HoldW-1:0] HoldLast  = HoldW'(HoldoffCycles - 1);
   localparam logic [DoneW-1:0] DoneLast  = DoneW'(DoneTimeoutCycles - 1);
   localparam logic [DebW-1:0]  DebMax    = DebW'(DebounceCycles - 1);
   localparam logic [DebW-1:0]  DebStable = DebW'(DebounceCycles - 2);

   localparam logic BtnReleasedRaw = (ButtonActiveLow != 0);
   localparam logic ReqInactive    = (RequestActiveLow != 0);

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      WAIT_DONE,
      HOLDOFF
   } state_t;

   // Internal reset: asserts with reset, releases two clocks after it.
   logic [1:0] rst_pipe;
   logic       rst_int;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of the others; blocking here would create order races.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rst_pipe <= 2'b11;
      else       rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst_int = rst_pipe[1];

   // ---------------------------------------------------------------------------
   // Input synchronizers
   // ---------------------------------------------------------------------------
   logic [SyncCycles-1:0] btn_sync;
   logic [SyncCycles-1:0] done_sync;
   logic                  btn_pressed;
   logic                  done_s;

   always_ff @(posedge clock or posedge rst_int) begin
      if (rst_int) begin
         btn_sync  <= {SyncCycles{BtnReleasedRaw}};
         done_sync <= '0;
      end else begin
         btn_sync  <= {btn_sync[SyncCycles-2:0], rr.buttonIn};
         done_sync <= {done_sync[SyncCycles-2:0], rr.resetDone};
      end
   end

   assign btn_pressed = btn_sync[SyncCycles-1] ^ BtnReleasedRaw;
   assign done_s      = done_sync[SyncCycles-1];

   // ---------------------------------------------------------------------------
   // Button debouncer: deb_cnt holds (run length - 1) of the current level.
   // ---------------------------------------------------------------------------
   logic            deb_level;
   logic            deb_armed;
   logic [DebW-1:0] deb_cnt;
   logic            deb_stable;
   logic            press_evt;

   assign deb_stable = (btn_pressed == deb_level) && (deb_cnt >= DebStable);
   assign press_evt  = deb_armed && deb_stable && deb_level;

   always_ff @(posedge clock or posedge rst_int) begin
      if (rst_int) begin
         deb_level <= 1'b0;
         deb_cnt   <= '0;
         deb_armed <= 1'b1;
      end else begin
         if (btn_pressed != deb_level) begin
            deb_level <= btn_pressed;
            deb_cnt   <= '0;
         end else if (deb_cnt != DebMax) begin
            deb_cnt <= deb_cnt + 1'b1;
         end

         if (press_evt)
            deb_armed <= 1'b0;
         else if (!deb_armed && deb_stable && !deb_level)
            deb_armed <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   logic wd_expire;

`ifdef OCLIB_RESET_REQUEST_WATCHDOG_EN
   localparam int             WdW    = (WatchdogCycles > 1) ? $clog2(WatchdogCycles) : 1;
   localparam logic [WdW-1:0] WdLast = WdW'(WatchdogCycles - 1);

   logic [WdW-1:0] wd_cnt;

   // A kick in the expiry cycle suppresses the expiry.
   assign wd_expire = rr.watchdogEnable && !rr.watchdogKick && (wd_cnt == WdLast);

   always_ff @(posedge clock or posedge rst_int) begin
      if (rst_int)
         wd_cnt <= '0;
      else if (!rr.watchdogEnable || rr.watchdogKick || wd_expire)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end
`else
   logic unused_wd;

   assign unused_wd = rr.watchdogEnable ^ rr.watchdogKick;
   assign wd_expire = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------
   state_t           state_q;
   state_t           state_d;
   logic [ReqW-1:0]  req_cnt;
   logic [DoneW-1:0] done_cnt;
   logic [HoldW-1:0] hold_cnt;
   logic             pending_q;
   logic             done_seen_low_q;
   logic             req_q;
   logic [3:0]       cause_q;
   logic [3:0]       cause_d;
   logic [7:0]       count_q;
   logic             trigger;
   logic             start_seq;
   logic             timeout_evt;

   assign trigger = rr.swRequest || press_evt || wd_expire;

   // NOTE: every signal driven here gets a default before the case statement,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      start_seq   = 1'b0;
      timeout_evt = 1'b0;

      case (state_q)
         IDLE: begin
            if (trigger || pending_q) begin
               state_d   = ASSERT;
               start_seq = 1'b1;
            end
         end
         ASSERT: begin
            if (req_cnt == ReqLast) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done_s && done_seen_low_q) begin
               state_d = HOLDOFF;
            end else if (done_cnt == DoneLast) begin
               state_d     = HOLDOFF;
               timeout_evt = 1'b1;
            end
         end
         HOLDOFF: begin
            if (hold_cnt == HoldLast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A cause set in the same cycle as causeClear survives the clear.
   always_comb begin
      cause_d = rr.causeClear ? 4'b0000 : cause_q;
      cause_d = cause_d | {timeout_evt, wd_expire, press_evt, rr.swRequest};
   end

   always_ff @(posedge clock or posedge rst_int) begin
      if (rst_int) begin
         state_q         <= IDLE;
         req_cnt         <= '0;
         done_cnt        <= '0;
         hold_cnt        <= '0;
         pending_q       <= 1'b0;
         done_seen_low_q <= 1'b0;
         req_q           <= 1'b0;
         cause_q         <= '0;
         count_q         <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         req_q   <= (state_d == ASSERT);

         // Phase counters run only while the phase persists, so they never wrap.
         req_cnt  <= (state_q == ASSERT    && state_d == ASSERT)    ? req_cnt  + 1'b1 : '0;
         done_cnt <= (state_q == WAIT_DONE && state_d == WAIT_DONE) ? done_cnt + 1'b1 : '0;
         hold_cnt <= (state_q == HOLDOFF   && state_d == HOLDOFF)   ? hold_cnt + 1'b1 : '0;

         if (state_q == HOLDOFF && trigger)
            pending_q <= 1'b1;
         else if (start_seq)
            pending_q <= 1'b0;

         if (state_q == IDLE)
            done_seen_low_q <= 1'b0;
         else if ((state_q == ASSERT || state_q == WAIT_DONE) && !done_s)
            done_seen_low_q <= 1'b1;

         if (start_seq && count_q != 8'hFF)
            count_q <= count_q + 1'b1;
      end
   end

   // Request comes straight from a flop, so it is glitch-free and drops with reset.
   assign rr.resetRequest = req_q ^ ReqInactive;
   assign rr.busy         = (state_q != IDLE);
   assign rr.cause        = cause_q;
   assign rr.requestCount = count_q;

endmodule

// File: tb/tb_oclib_reset_request.sv
// Scoreboard bench for oclib_reset_request: a timestamp-based reference model
// predicts sequence start/end events; a monitor checks them as the DUT shows them.
module tb_oclib_reset_request;

   localparam int R   = 4;
   localparam int H   = 8;
   localparam int T   = 50;
   localparam int D   = 16;
   localparam int W   = 100;
   localparam int S   = 3;
   localparam int BAL = 1;
   localparam int RAL = 0;
   localparam logic BTN_RELEASED = 1'b1;
   localparam logic BTN_PRESSED  = 1'b0;

   logic clock = 1'b0;
   logic reset = 1'b1;

   oclib_reset_request_if rr ();

   oclib_reset_request #(
      .RequestCycles(R), .HoldoffCycles(H), .DoneTimeoutCycles(T),
      .DebounceCycles(D), .WatchdogCycles(W), .SyncCycles(S),
      .ButtonActiveLow(BAL), .RequestActiveLow(RAL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .rr   (rr)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef enum {M_IDLE, M_REQ, M_WAIT, M_HOLD} mphase_t;
   typedef struct { int cyc; int count; } start_exp_t;

   start_exp_t start_q[$];
   int         end_q[$];

   int         cyc = 0;
   logic       hist_btn [0:63];
   logic       hist_done[0:63];
   mphase_t    m_phase = M_IDLE;
   int         m_start, m_mark;
   logic       m_pending, m_dsl;
   logic [3:0] m_cause;
   int         m_count;
   int         m_skip;
   logic       deb_last, deb_armed;
   int         deb_run;
   int         wd_run;

   task automatic model_reset();
      m_phase   = M_IDLE;
      m_pending = 1'b0;
      m_dsl     = 1'b0;
      m_cause   = 4'b0000;
      m_count   = 0;
      deb_last  = 1'b0;
      deb_run   = 1;
      deb_armed = 1'b1;
      wd_run    = 0;
      start_q.delete();
      end_q.delete();
   endtask

   task automatic model_step();
      logic       bp, ds, press, wdexp, trig;
      logic [3:0] nc;
      bp = hist_btn[(cyc - S) % 64];
      ds = hist_done[(cyc - S) % 64];

      // Debounce: an event once the pressed level has persisted D cycles.
      if (bp == deb_last) deb_run++;
      else begin deb_last = bp; deb_run = 1; end
      press = 1'b0;
      if (deb_run >= D) begin
         if (bp && deb_armed) begin press = 1'b1; deb_armed = 1'b0; end
         else if (!bp) deb_armed = 1'b1;
      end

      wdexp = 1'b0;
`ifdef OCLIB_RESET_REQUEST_WATCHDOG_EN
      if (!rr.watchdogEnable || rr.watchdogKick) wd_run = 0;
      else begin
         wd_run++;
         if (wd_run == W) begin wdexp = 1'b1; wd_run = 0; end
      end
`endif
      trig = rr.swRequest | press | wdexp;
      nc   = rr.causeClear ? 4'b0000 : m_cause;
      nc   = nc | {1'b0, wdexp, press, rr.swRequest};

      case (m_phase)
         M_IDLE: begin
            m_dsl = 1'b0;
            if (trig || m_pending) begin
               m_phase   = M_REQ;
               m_start   = cyc;
               m_pending = 1'b0;
               if (m_count < 255) m_count++;
               start_q.push_back('{cyc, m_count});
            end
         end
         M_REQ: begin
            if (!ds) m_dsl = 1'b1;
            if (cyc - m_start == R) begin m_phase = M_WAIT; m_mark = cyc; end
         end
         M_WAIT: begin
            if (ds && m_dsl) begin
               m_phase = M_HOLD; m_mark = cyc;
            end else if (cyc - m_mark == T) begin
               nc[3] = 1'b1; m_phase = M_HOLD; m_mark = cyc;
            end
            if (!ds) m_dsl = 1'b1;
         end
         M_HOLD: begin
            if (trig) m_pending = 1'b1;
            if (cyc - m_mark == H) begin m_phase = M_IDLE; end_q.push_back(cyc); end
         end
         default: ;
      endcase
      m_cause = nc;
   endtask

   // The DUT ignores two edges after reset release; synchronizers hold reset values.
   always @(posedge clock) begin
      logic in_rst;
      cyc++;
      in_rst = reset || (m_skip > 0);
      hist_btn[cyc % 64]  = in_rst ? 1'b0 : (rr.buttonIn ^ logic'(BAL));
      hist_done[cyc % 64] = in_rst ? 1'b0 : rr.resetDone;
      if (reset) begin
         model_reset();
         m_skip = 2;
      end else if (m_skip > 0) begin
         m_skip--;
      end else begin
         model_step();
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   logic mon_req = 1'b0, mon_busy = 1'b0;
   int   mon_rise = 0;

   always @(negedge clock) begin
      logic       req;
      start_exp_t e;
      int         ec;
      if (reset) begin
         mon_req  = 1'b0;
         mon_busy = 1'b0;
      end else begin
         req = rr.resetRequest ^ logic'(RAL);
         if (req && !mon_req) begin
            check("busy_at_start", rr.busy, 1);
            if (start_q.size() == 0) check("start_expected", start_q.size(), 1);
            else begin
               e = start_q.pop_front();
               check("start_cycle", cyc, e.cyc);
               check("start_count", rr.requestCount, e.count);
            end
            mon_rise = cyc;
         end
         if (!req && mon_req) check("req_width", cyc - mon_rise, R);
         if (!rr.busy && mon_busy) begin
            if (end_q.size() == 0) check("end_expected", end_q.size(), 1);
            else begin
               ec = end_q.pop_front();
               check("end_cycle", cyc, ec);
            end
         end
         mon_req  = req;
         mon_busy = rr.busy;
      end
   end

   // ---------------------------------------------------------------------------
   // Downstream responder: drops done while requested, re-raises it later.
   // ---------------------------------------------------------------------------
   logic resp_stuck = 1'b0;
   int   resp_min = 0, resp_max = 20, resp_wait = 0;

   always @(negedge clock) begin
      if (resp_stuck) rr.resetDone = 1'b1;
      else if ((rr.resetRequest ^ logic'(RAL)) === 1'b1) begin
         rr.resetDone = 1'b0;
         resp_wait    = $urandom_range(resp_max, resp_min);
      end else if (resp_wait > 0) resp_wait--;
      else rr.resetDone = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_sw();
      @(negedge clock); rr.swRequest = 1'b1;
      @(negedge clock); rr.swRequest = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clock); rr.causeClear = 1'b1;
      @(negedge clock); rr.causeClear = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max);
      int   n = 0;
      logic ok;
      do begin
         @(negedge clock); #1; n++;
         ok = (m_phase == M_IDLE) && !m_pending && !rr.busy && (start_q.size() == 0);
      end while (!ok && n < max);
      check({name, "_idle_reached"}, ok, 1);
   endtask

   task automatic check_vs_model(input string name);
      check({name, "_cause"}, rr.cause, m_cause);
      check({name, "_count"}, rr.requestCount, m_count);
      check({name, "_busy"}, rr.busy, 0);
      check({name, "_end_q_empty"}, end_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   initial begin
      int saved;
      int btn_left;
      logic hold_ok;

      rr.swRequest      = 1'b0;
      rr.buttonIn       = BTN_RELEASED;
      rr.watchdogEnable = 1'b0;
      rr.watchdogKick   = 1'b0;
      rr.causeClear     = 1'b0;

      cycles(4); #1;
      check("rst_request_inactive", rr.resetRequest, RAL);
      check("rst_busy", rr.busy, 0);
      check("rst_cause", rr.cause, 0);
      check("rst_count", rr.requestCount, 0);
      @(negedge clock); reset = 1'b0;
      cycles(5);

      // 1: software request with a well-behaved downstream domain
      resp_min = 5; resp_max = 5;
      pulse_sw();
      wait_idle("t1", 200);
      check("t1_cause_lit", rr.cause, 4'b0001);
      check("t1_count_lit", rr.requestCount, 1);
      check_vs_model("t1");
      resp_min = 0; resp_max = 20;

      // 2: bouncing button, then one clean press
      pulse_clear();
      saved = m_count;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock); rr.buttonIn = ~rr.buttonIn;
         cycles(4);
      end
      cycles(S + 2); #1;
      check("t2_no_seq_bounce", rr.busy, 0);
      @(negedge clock); rr.buttonIn = BTN_PRESSED;
      cycles(40);
      @(negedge clock); rr.buttonIn = BTN_RELEASED;
      cycles(30);
      wait_idle("t2", 300);
      check("t2_cause1_lit", rr.cause[1], 1);
      check("t2_count_lit", rr.requestCount, saved + 1);
      check_vs_model("t2");

      // 3: watchdog
      pulse_clear();
      saved = m_count;
`ifdef OCLIB_RESET_REQUEST_WATCHDOG_EN
      @(negedge clock); rr.watchdogEnable = 1'b1;
      cycles(150); #1;
      check("t3_wd_count_lit", rr.requestCount, saved + 1);
      check("t3_wd_cause2_lit", rr.cause[2], 1);
      @(negedge clock); rr.watchdogEnable = 1'b0;
      wait_idle("t3a", 300);
      check_vs_model("t3a");
      pulse_clear();
      saved = m_count;
      @(negedge clock); rr.watchdogEnable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); rr.watchdogKick = 1'b1;
         @(negedge clock); rr.watchdogKick = 1'b0;
         cycles(48);
      end
      @(negedge clock); rr.watchdogEnable = 1'b0;
      #1;
      check("t3_kick_count", rr.requestCount, saved);
      check("t3_kick_cause2", rr.cause[2], 0);
      check_vs_model("t3b");
`else
      @(negedge clock); rr.watchdogEnable = 1'b1;
      cycles(300);
      @(negedge clock); rr.watchdogEnable = 1'b0;
      #1;
      check("t3_nowd_cause2", rr.cause[2], 0);
      check("t3_nowd_count", rr.requestCount, saved);
      check_vs_model("t3");
`endif

      // 4: downstream never reports done -> timeout
      pulse_clear();
      resp_stuck = 1'b1;
      pulse_sw();
      wait_idle("t4", 300);
      check("t4_cause3_lit", rr.cause[3], 1);
      check_vs_model("t4");
      resp_stuck = 1'b0;
      cycles(5);

      // 5: merged request during ASSERT, pending request during HOLDOFF
      pulse_clear();
      saved = m_count;
      pulse_sw();
      cycles(2);
      pulse_sw();
      hold_ok = 1'b0;
      for (int i = 0; i < 300 && !hold_ok; i++) begin
         @(negedge clock); #1;
         hold_ok = (m_phase == M_HOLD);
      end
      check("t5_hold_reached", hold_ok, 1);
      pulse_sw();
      wait_idle("t5", 400);
      check("t5_count_lit", rr.requestCount, saved + 2);
      check_vs_model("t5");

      // 6: reset in the middle of ASSERT
      pulse_sw();
      hold_ok = 1'b0;
      for (int i = 0; i < 20 && !hold_ok; i++) begin
         @(negedge clock);
         hold_ok = ((rr.resetRequest ^ logic'(RAL)) === 1'b1);
      end
      check("t6_request_seen", hold_ok, 1);
      #2 reset = 1'b1;
      #1;
      check("t6_async_request", rr.resetRequest, RAL);
      check("t6_async_busy", rr.busy, 0);
      check("t6_async_cause", rr.cause, 0);
      check("t6_async_count", rr.requestCount, 0);
      cycles(3);
      @(negedge clock); reset = 1'b0;
      cycles(40); #1;
      check("t6_post_count", rr.requestCount, 0);
      check("t6_post_busy", rr.busy, 0);
      check_vs_model("t6");

      // Random mix of all causes against the model
      resp_min = 0; resp_max = 60;
      btn_left = 10;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         rr.swRequest    = ($urandom_range(0, 39) == 0);
         rr.causeClear   = ($urandom_range(0, 49) == 0);
         rr.watchdogKick = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 199) == 0) rr.watchdogEnable = ~rr.watchdogEnable;
         if (btn_left == 0) begin
            rr.buttonIn = ~rr.buttonIn;
            btn_left    = $urandom_range(2, 40);
         end else btn_left--;
         if (i % 50 == 49) begin
            #1;
            check("rand_cause", rr.cause, m_cause);
            check("rand_count", rr.requestCount, m_count);
         end
      end
      @(negedge clock);
      rr.swRequest = 1'b0; rr.causeClear = 1'b0; rr.watchdogKick = 1'b0;
      rr.watchdogEnable = 1'b0; rr.buttonIn = BTN_RELEASED;
      cycles(D + 2 * S);
      wait_idle("rand", 2000);
      check_vs_model("rand");
      check("final_start_q_empty", start_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/oclib_reset_request.md
Name: oclib_reset_request

Overview:
- Initiator side of the reset-generator interface: collects reset causes and drives a clean, minimum-width request into a downstream reset generator's reset input.
- Then waits for the downstream domain to report reset-done.
- Sits in an always-on clock domain; never reset by its own request.
- Causes: software pulse, debounced pushbutton, optional watchdog.

Parameters:
RequestCycles, 16, cycles resetRequest is held asserted (>=2)
HoldoffCycles, 64, cycles after a sequence before a new one may start (>=1)
DoneTimeoutCycles, 4096, max cycles to wait for resetDone high
DebounceCycles, 1024, stable-level cycles required on button (>=2)
WatchdogCycles, 1048576, watchdog expiry period (>=2)
SyncCycles, 3, synchronizer depth for button and resetDone (>=2)
ButtonActiveLow, 1, button polarity
RequestActiveLow, 0, resetRequest polarity

Ports:
clock  input  1  block clock
reset  input  1  asynchronous, active-high reset
swRequest  input  1  single-cycle software reset request
buttonIn  input  1  asynchronous pushbutton, polarity per ButtonActiveLow
watchdogEnable  input  1  watchdog counting enable
watchdogKick  input  1  clears watchdog counter
resetDone  input  1  asynchronous done indication from downstream domain
causeClear  input  1  clears the cause register
resetRequest  output  1  request to downstream reset generator
busy  output  1  high whenever state != IDLE
cause  output  4  sticky flags {doneTimeout, watchdog, button, sw}
requestCount  output  8  saturating count of sequences started

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - resetRequest inactive level; busy=0; cause=0; requestCount=0.
  - All counters 0; pending=0.
  - Button debouncer is in the released state.
- Trigger: OR of swRequest, button press event, watchdog expiry. Every triggering source sets its cause bit the same cycle, including simultaneous sources.
- causeClear clears cause; a same-cycle set wins over clear.
- FSM:
  - IDLE: on trigger (or pending=1) -> ASSERT next cycle. resetRequest active in the first ASSERT cycle (latency 1 from swRequest). requestCount += 1, saturating at 255. pending cleared.
  - ASSERT: resetRequest active exactly RequestCycles cycles, then -> WAIT_DONE.
  - WAIT_DONE: resetRequest inactive.
    - doneSeenLow is set when synced resetDone is low during ASSERT or WAIT_DONE.
    - Exits to HOLDOFF on the first cycle synced resetDone=1 with doneSeenLow=1.
    - If DoneTimeoutCycles elapse in WAIT_DONE: set cause[3] and go to HOLDOFF.
  - HOLDOFF: HoldoffCycles cycles, then -> IDLE.
- Triggers during ASSERT/WAIT_DONE: merged into the current sequence (cause bits set, no new sequence).
- Triggers during HOLDOFF: set pending, so exactly one further sequence starts when IDLE is reached.
- Button:
  - SyncCycles synchronizer, then a debounce counter. The counter resets whenever the synced level changes.
  - A press event is a single pulse when the pressed level has been stable DebounceCycles cycles.
  - Re-arm requires a released level stable DebounceCycles cycles.
- resetDone: SyncCycles synchronizer before use.
- reset asserted mid-sequence:
  - resetRequest goes inactive immediately and asynchronously; all state clears.
  - After release: no sequence restarts without a new trigger.
- Counter widths: $clog2 of the respective parameter. No wrap: counters stop at terminal value.

Optional Feature:
- Macro OCLIB_RESET_REQUEST_WATCHDOG_EN.
- Defined:
  - Watchdog counter increments while watchdogEnable=1; watchdogKick or watchdogEnable=0 clears it.
  - On reaching WatchdogCycles-1: one-cycle expiry trigger, cause[2] set, counter clears.
  - Kick and expiry in the same cycle: the kick wins, so no expiry.
- Undefined: no watchdog logic; watchdogEnable/watchdogKick are ignored; cause[2] is constant 0.

Test Plan:
(Parameters RequestCycles=4, HoldoffCycles=8, DoneTimeoutCycles=50, DebounceCycles=16, WatchdogCycles=100, SyncCycles=3.)
1. swRequest pulse at cycle 10; resetDone drops then rises at 20 -> resetRequest active cycles 11-14, cause=4'b0001, requestCount=1, busy returns to 0 after holdoff ends.
2. Button bounces every 5 cycles for 60 cycles, then is held pressed 40 cycles -> exactly one sequence, cause[1]=1; no sequence during bouncing.
3. With OCLIB_RESET_REQUEST_WATCHDOG_EN, watchdogEnable=1 and no kick -> trigger 100 cycles after enable, cause[2]=1. With a kick every 50 cycles -> no trigger over 1000 cycles.
4. resetDone held high throughout -> WAIT_DONE times out after 50 cycles, cause[3]=1, HOLDOFF entered.
5. swRequest during ASSERT, then again during HOLDOFF -> first is merged, second starts exactly one new sequence after holdoff; requestCount=2.
6. Assert reset mid-ASSERT -> resetRequest inactive in the same cycle (asynchronously), cause=0, requestCount=0, no sequence after release.
